// File: rtl/gate_td_pipe.sv
// rtl/gate_td_pipe.sv - WIDTH-bit selectable gate with transport/inertial output delay
module gate_td_pipe #(
  parameter int WIDTH  = 4,
  parameter int DELAY  = 3,
  parameter int GCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [1:0]        mode,
  input  logic              inertial,
  output logic [WIDTH-1:0]  w,
  output logic              changed,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(DELAY) + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] stage   [DELAY];
  logic [WIDTH-1:0] stage_n [DELAY];
  cnt_t             cnt     [WIDTH];
  cnt_t             cnt_n   [WIDTH];
  logic             inertial_q;
  logic             reject;

  always_comb begin
    f = '0;
    case (mode)
      2'b00:   f = ~(a & b);
      2'b01:   f = a & b;
      2'b10:   f = a | b;
      default: f = a ^ b;
    endcase
  end

  // The last stage doubles as the output register in both delay modes.
  assign w = stage[DELAY-1];

  always_comb begin
    stage_n = stage;
    cnt_n   = cnt;
    reject  = 1'b0;
    if (inertial != inertial_q) begin
      // Mode switch: flush history to the current output and hold it.
      for (int j = 0; j < DELAY; j++) stage_n[j] = w;
      for (int i = 0; i < WIDTH; i++) cnt_n[i] = '0;
    end else if (!inertial_q) begin
      stage_n[0] = f;
      for (int j = 1; j < DELAY; j++) stage_n[j] = stage[j-1];
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (f[i] == w[i]) begin
          if (cnt[i] != '0) reject = 1'b1;
          cnt_n[i] = '0;
        end else if (cnt[i] == cnt_t'(DELAY - 1)) begin
          stage_n[DELAY-1][i] = f[i];
          cnt_n[i] = '0;
        end else begin
          cnt_n[i] = cnt[i] + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DELAY; j++) stage[j] <= '1;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      inertial_q <= 1'b0;
      changed    <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      stage      <= stage_n;
      cnt        <= cnt_n;
      inertial_q <= inertial;
      changed    <= (stage_n[DELAY-1] != w);
      if (reject && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + GCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_td_pipe.sv
// tb/tb_gate_td_pipe.sv - directed self-checking bench for gate_td_pipe
module tb_gate_td_pipe;

  localparam int WIDTH  = 4;
  localparam int DELAY  = 3;
  localparam int GCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  a, b;
  logic [1:0]        mode;
  logic              inertial;
  logic [WIDTH-1:0]  w;
  logic              changed;
  logic [GCNT_W-1:0] glitch_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  logic chg_seen;
  logic w_bad;

  always #5 clk = ~clk;

  gate_td_pipe #(.WIDTH(WIDTH), .DELAY(DELAY), .GCNT_W(GCNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .inertial   (inertial),
    .w          (w),
    .changed    (changed),
    .glitch_cnt (glitch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-edge NAND pulse (f=0 for a single sampled edge) from an all-ones output.
  task automatic pulse;
    a = 4'hF; b = 4'hF;
    tick();
    chg_seen = chg_seen | changed;
    w_bad    = w_bad | (w !== 4'hF);
    a = 4'h0; b = 4'h0;
    tick();
    chg_seen = chg_seen | changed;
    w_bad    = w_bad | (w !== 4'hF);
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; mode = 2'b00; inertial = 1'b0;
    chg_seen = 1'b0; w_bad = 1'b0;
    tick(2);
    chk("rst_w", 32'(w), 32'hF);
    chk("rst_changed", 32'(changed), 32'h0);
    chk("rst_gcnt", 32'(glitch_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // Transport step: f=0 from edge k
    a = 4'hF; b = 4'hF;
    tick(2);
    chk("tr_step_k1_w", 32'(w), 32'hF);
    tick();
    chk("tr_step_k2_w", 32'(w), 32'h0);
    chk("tr_step_k2_chg", 32'(changed), 32'h1);
    tick();
    chk("tr_step_k3_w", 32'(w), 32'h0);
    chk("tr_step_k3_chg", 32'(changed), 32'h0);

    // Asynchronous reset between edges while w=0
    a = 4'h0; b = 4'h0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_w", 32'(w), 32'hF);
    chk("async_rst_chg", 32'(changed), 32'h0);
    chk("async_rst_gcnt", 32'(glitch_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_w", 32'(w), 32'hF);
    chk("post_rst_chg", 32'(changed), 32'h0);

    // Transport one-edge pulse
    a = 4'hF; b = 4'hF;
    tick();
    a = 4'h0; b = 4'h0;
    tick(2);
    chk("tr_pulse_on_w", 32'(w), 32'h0);
    chk("tr_pulse_on_chg", 32'(changed), 32'h1);
    tick();
    chk("tr_pulse_off_w", 32'(w), 32'hF);
    chk("tr_pulse_off_chg", 32'(changed), 32'h1);
    tick();
    chk("tr_pulse_idle_chg", 32'(changed), 32'h0);
    chk("tr_pulse_gcnt", 32'(glitch_cnt), 32'h0);

    // Inertial reject of a one-edge pulse
    inertial = 1'b1;
    tick(2);
    chk("in_switch_w", 32'(w), 32'hF);
    pulse();
    chk("in_rej_w", 32'(w), 32'hF);
    chk("in_rej_chg", 32'(changed), 32'h0);
    chk("in_rej_gcnt", 32'(glitch_cnt), 32'h1);

    // Inertial accept: three consecutive differing edges
    a = 4'hF; b = 4'hF;
    tick(2);
    chk("in_acc_k1_w", 32'(w), 32'hF);
    tick();
    chk("in_acc_k2_w", 32'(w), 32'h0);
    chk("in_acc_k2_chg", 32'(changed), 32'h1);
    a = 4'h0; b = 4'h0;
    tick();
    chk("in_acc_k3_w", 32'(w), 32'h0);
    chk("in_acc_k3_chg", 32'(changed), 32'h0);
    tick();
    chk("in_acc_k4_w", 32'(w), 32'h0);
    tick();
    chk("in_acc_k5_w", 32'(w), 32'hF);
    chk("in_acc_k5_chg", 32'(changed), 32'h1);
    chk("in_acc_gcnt", 32'(glitch_cnt), 32'h1);

    // Saturation of glitch_cnt over 300 total rejected pulses
    chg_seen = 1'b0; w_bad = 1'b0;
    repeat (253) pulse();
    chk("sat_254", 32'(glitch_cnt), 32'd254);
    pulse();
    chk("sat_255", 32'(glitch_cnt), 32'd255);
    repeat (45) pulse();
    chk("sat_hold", 32'(glitch_cnt), 32'd255);
    chk("sat_no_chg", 32'(chg_seen), 32'h0);
    chk("sat_w_stable", 32'(w_bad), 32'h0);

    // XOR in transport, then switch to inertial and reject a 2-edge change
    inertial = 1'b0;
    rst_n = 1'b0;
    tick();
    mode = 2'b11; a = 4'h5; b = 4'h3;
    rst_n = 1'b1;
    tick(2);
    chk("xor_k1_w", 32'(w), 32'hF);
    tick();
    chk("xor_k2_w", 32'(w), 32'h6);
    chk("xor_k2_chg", 32'(changed), 32'h1);
    inertial = 1'b1;
    tick();
    chk("xor_switch_w", 32'(w), 32'h6);
    chk("xor_switch_chg", 32'(changed), 32'h0);
    tick();
    b = 4'h0;
    tick(2);
    chk("xor_pend_w", 32'(w), 32'h6);
    chk("xor_pend_gcnt", 32'(glitch_cnt), 32'h0);
    b = 4'h3;
    tick();
    chk("xor_rej_w", 32'(w), 32'h6);
    chk("xor_rej_gcnt", 32'(glitch_cnt), 32'h1);

    // Back to transport; AND and OR functions
    inertial = 1'b0;
    tick();
    chk("back_tr_w", 32'(w), 32'h6);
    mode = 2'b01;
    tick(2);
    chk("and_k1_w", 32'(w), 32'h6);
    tick();
    chk("and_k2_w", 32'(w), 32'h1);
    mode = 2'b10;
    tick(3);
    chk("or_k2_w", 32'(w), 32'h7);
    chk("tr_gcnt_held", 32'(glitch_cnt), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_td_pipe.md
Name: gate_td_pipe

Overview:
Parametrised successor to the single-bit NAND delay gate. It is a WIDTH-bit bitwise two-input gate with a selectable function and an output delay of DELAY clock cycles. The delay runs in either transport mode (every input change is reproduced) or inertial mode (pulses shorter than DELAY cycles are swallowed and counted). It is used as a synthesizable gate-delay model in course labs and as a glitch-filtering stage on sampled inputs.

Parameters:
WIDTH, 4, bit width of a, b, w
DELAY, 3, output delay in clock cycles; legal range 1..16
GCNT_W, 8, width of glitch counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A
b  input  WIDTH  operand B
mode  input  2  gate function: 00 NAND, 01 AND, 10 OR, 11 XOR
inertial  input  1  0 transport delay, 1 inertial delay
w  output  WIDTH  delayed gate output (registered)
changed  output  1  one-cycle pulse on any cycle w changes
glitch_cnt  output  GCNT_W  saturating count of rejected-pulse cycles

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low, and fixed as such.
- Reset (immediate on rst_n low, independent of clk):
  - w = {WIDTH{1'b1}} (NAND of 0,0)
  - all pipeline stages = all ones
  - per-bit counters = 0
  - changed = 0
  - glitch_cnt = 0
  - inertial_q = 0
- After reset deasserts, the first active edge behaves as normal operation.
- f = mode-selected bitwise function of a and b. It is combinational and sampled at each rising edge. A mode change affects only values sampled from that edge onward.
- Latency (both modes): a stable f sampled at edge k appears on w just after edge k+DELAY-1. With DELAY=1, w is a plain register of f.
- Transport mode:
  - Shift chain of DELAY WIDTH-bit stages; w is the last stage.
  - Every sampled value, including 1-cycle pulses, is reproduced on w with exact width and order.
- Inertial mode, per bit i, with counter cnt_i of width clog2(DELAY)+1, at each edge:
  - f[i]==w[i]: cnt_i<=0. If cnt_i was nonzero, this is a rejected pulse.
  - f[i]!=w[i] and cnt_i==DELAY-1: w[i]<=f[i]; cnt_i<=0.
  - f[i]!=w[i] otherwise: cnt_i<=cnt_i+1.
  - Net effect: w[i] follows only after f[i] differs from w[i] on DELAY consecutive edges. DELAY=1 is identical to transport.
- glitch_cnt:
  - Increments by 1 on each edge where at least one bit has a rejected pulse (one increment per edge, not per bit).
  - Saturates at 2^GCNT_W-1.
  - Never increments in transport mode.
  - Cleared only by reset.
- Mode switch: inertial is registered as inertial_q. On an edge where inertial differs from inertial_q:
  - all pipeline stages are loaded with the current w
  - all cnt_i are cleared
  - w holds
  - new-mode behaviour starts the following edge
- changed is a registered pulse, high for exactly the cycle after an edge where w's new value differs from its old value.
- A reset asserted mid-pulse or mid-count discards all pending values. No pending change is emitted after reset release.

Test Plan:
(All with WIDTH=4, DELAY=3, mode=NAND unless noted.)
1. Reset: assert rst_n=0 between edges while w=0 -> w=4'hF, changed=0, glitch_cnt=0 immediately, no clock required; after release with a=b=0, w stays 4'hF.
2. Transport: a=b=4'hF sampled from edge k onward -> w=4'h0 just after edge k+2; changed high exactly one cycle; w unchanged on later edges.
3. Transport pulse: a=b=4'hF at edge k only, 0 otherwise -> w=4'h0 for exactly one cycle (after k+2), 4'hF after k+3; changed pulses twice; glitch_cnt stays 0.
4. Inertial reject: same 1-cycle pulse with inertial=1 (set ≥2 edges before) -> w stays 4'hF throughout, changed never asserts, glitch_cnt=1. Repeat 300 pulses -> glitch_cnt saturates at 255.
5. Inertial accept: a=b=4'hF for edges k..k+2, then 0 -> w=4'h0 after k+2; w=4'hF after k+5; glitch_cnt unchanged.
6. XOR with a mode switch: mode=XOR, a=4'h5, b=4'h3 held -> w=4'h6 three edges later. Toggle inertial mid-stream -> w holds 4'h6, and a subsequent 2-cycle change of b to 4'h0 is rejected (glitch_cnt +1).
